// File: rtl/ahb_apb_bridge.sv
// ---------------------------------------------------------------------------
// ahb_apb_bridge
//
// AHB-Lite slave to APB master bridge for three APB slaves, each decoded over
// a 64 KB window at HADDR[31:16] == SLV_BASE + n (n = 0..2). Every accepted
// AHB transfer becomes one APB SETUP+ACCESS transfer, and the AHB master is
// stalled with HREADY_OUT until that transfer completes. Unmapped addresses
// get a two-cycle ERROR response and generate no APB traffic.
//
// Build option:
//   AHB_APB_RDATA_DELAY_EN - reads spend one extra cycle (RWAIT) after ACCESS
//                            and HRDATA is captured at the end of RWAIT. This
//                            suits slaves that register PRDATA on the ACCESS
//                            edge. Writes are unaffected.
//
// Ports:
//   HCLK, PRESETn         clock (rising edge), async active-low reset
//   HADDR, HWDATA         AHB address / write data (data phase)
//   HTRANS, HWRITE        AHB transfer type / direction
//   HSIZE, HBURST         unused: all accesses are 32-bit single beats
//   HREADY_IN             AHB bus ready
//   HRDATA                registered read data
//   HREADY_OUT, HRESP     bridge ready / response (00 OKAY, 01 ERROR)
//   PADDR, PWDATA,
//   PSEL, PENABLE, PWRITE APB master outputs (PSEL one-hot)
//   PRDATA                muxed APB read data
//
// States:
//   state  | meaning
//   IDLE   | ready; waits for an accepted transfer
//   LATCH  | data phase; HWDATA captured into PWDATA for writes
//   SETUP  | APB setup: PSEL asserted, PENABLE low
//   ACCESS | APB access: PSEL and PENABLE asserted
//   RWAIT  | (option only) read data settling cycle, HRDATA captured at end
//   ERR1   | first ERROR cycle, HREADY_OUT low
//   ERR2   | second ERROR cycle, HREADY_OUT high
// ---------------------------------------------------------------------------
module ahb_apb_bridge #(
  parameter logic [15:0] SLV_BASE = 16'h8000
) (
  input  logic        HCLK,
  input  logic        PRESETn,
  input  logic [31:0] HADDR,
  input  logic [31:0] HWDATA,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic        HREADY_IN,
  output logic [31:0] HRDATA,
  output logic        HREADY_OUT,
  output logic [1:0]  HRESP,
  output logic [31:0] PADDR,
  output logic [31:0] PWDATA,
  output logic [2:0]  PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  input  logic [31:0] PRDATA
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LATCH  = 3'd1,
    ST_SETUP  = 3'd2,
    ST_ACCESS = 3'd3,
    ST_ERR1   = 3'd4,
    ST_ERR2   = 3'd5
`ifdef AHB_APB_RDATA_DELAY_EN
    , ST_RWAIT = 3'd6
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  sel_q, sel_d;
  logic [31:0] paddr_q, paddr_d;
  logic        pwrite_q, pwrite_d;
  logic [31:0] pwdata_q, pwdata_d;
  logic [31:0] hrdata_q, hrdata_d;

  logic        hready_out;
  logic [1:0]  hresp;
  logic [2:0]  psel;
  logic        penable;

  logic [2:0]  dec_sel;
  logic        accept;
  logic        rdata_capture;

  // Size, burst type and the SEQ/NONSEQ distinction carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{HSIZE, HBURST, HTRANS[0]};

  always_comb begin
    dec_sel    = 3'b000;
    dec_sel[0] = (HADDR[31:16] == SLV_BASE);
    dec_sel[1] = (HADDR[31:16] == SLV_BASE + 16'd1);
    dec_sel[2] = (HADDR[31:16] == SLV_BASE + 16'd2);
  end

  // Transfers are only taken in IDLE; anything presented while the bridge is
  // busy (including during ERR2, where HREADY_OUT is already high) is ignored.
  assign accept = (state_q == ST_IDLE) && HTRANS[1] && HREADY_IN && hready_out;

`ifdef AHB_APB_RDATA_DELAY_EN
  assign rdata_capture = (state_q == ST_RWAIT);
`else
  assign rdata_capture = (state_q == ST_ACCESS) && !pwrite_q;
`endif

  // State register
  always_ff @(posedge HCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = (dec_sel != 3'b000) ? ST_LATCH : ST_ERR1;
        end
      end
      ST_LATCH:  state_d = ST_SETUP;
      ST_SETUP:  state_d = ST_ACCESS;
`ifdef AHB_APB_RDATA_DELAY_EN
      ST_ACCESS: state_d = pwrite_q ? ST_IDLE : ST_RWAIT;
      ST_RWAIT:  state_d = ST_IDLE;
`else
      ST_ACCESS: state_d = ST_IDLE;
`endif
      ST_ERR1:   state_d = ST_ERR2;
      ST_ERR2:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output decode of the registered state
  always_comb begin
    hready_out = 1'b0;
    hresp      = 2'b00;
    psel       = 3'b000;
    penable    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        hready_out = 1'b1;
      end
      ST_SETUP: begin
        psel = sel_q;
      end
      ST_ACCESS: begin
        psel    = sel_q;
        penable = 1'b1;
      end
      ST_ERR1: begin
        hresp = 2'b01;
      end
      ST_ERR2: begin
        hready_out = 1'b1;
        hresp      = 2'b01;
      end
      default: begin
        hready_out = 1'b0;
      end
    endcase
  end

  // Datapath: address/direction latched on accept, write data in the data
  // phase, read data at the capture point. All hold otherwise.
  always_comb begin
    sel_d    = sel_q;
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    hrdata_d = hrdata_q;
    if (accept) begin
      sel_d    = dec_sel;
      paddr_d  = HADDR;
      pwrite_d = HWRITE;
    end
    if ((state_q == ST_LATCH) && pwrite_q) begin
      pwdata_d = HWDATA;
    end
    if (rdata_capture) begin
      hrdata_d = PRDATA;
    end
  end

  always_ff @(posedge HCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      sel_q    <= 3'b000;
      paddr_q  <= 32'h0;
      pwrite_q <= 1'b0;
      pwdata_q <= 32'h0;
      hrdata_q <= 32'h0;
    end else begin
      sel_q    <= sel_d;
      paddr_q  <= paddr_d;
      pwrite_q <= pwrite_d;
      pwdata_q <= pwdata_d;
      hrdata_q <= hrdata_d;
    end
  end

  assign HRDATA     = hrdata_q;
  assign HREADY_OUT = hready_out;
  assign HRESP      = hresp;
  assign PADDR      = paddr_q;
  assign PWDATA     = pwdata_q;
  assign PSEL       = psel;
  assign PENABLE    = penable;
  assign PWRITE     = pwrite_q;

endmodule

// File: tb/tb_ahb_apb_bridge.sv
`timescale 1ns/1ps
module tb_ahb_apb_bridge;

  localparam logic [15:0] SLV_BASE = 16'h8000;
`ifdef AHB_APB_RDATA_DELAY_EN
  localparam int RD_STALL = 4;
`else
  localparam int RD_STALL = 3;
`endif

  logic        HCLK = 1'b0;
  logic        PRESETn = 1'b1;
  logic [31:0] HADDR = '0;
  logic [31:0] HWDATA = '0;
  logic [1:0]  HTRANS = 2'b00;
  logic        HWRITE = 1'b0;
  logic [2:0]  HSIZE = 3'b010;
  logic [2:0]  HBURST = 3'b000;
  logic        HREADY_IN = 1'b1;
  logic [31:0] HRDATA;
  logic        HREADY_OUT;
  logic [1:0]  HRESP;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [2:0]  PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PRDATA;

  always #5 HCLK = ~HCLK;

  ahb_apb_bridge #(.SLV_BASE(SLV_BASE)) dut (
    .HCLK(HCLK), .PRESETn(PRESETn), .HADDR(HADDR), .HWDATA(HWDATA),
    .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HREADY_IN(HREADY_IN), .HRDATA(HRDATA), .HREADY_OUT(HREADY_OUT),
    .HRESP(HRESP), .PADDR(PADDR), .PWDATA(PWDATA), .PSEL(PSEL),
    .PENABLE(PENABLE), .PWRITE(PWRITE), .PRDATA(PRDATA)
  );

  // ---------------- zero-wait register-file slaves ----------------
  logic [31:0] slv_mem [3][16] = '{default: '0};
  logic [31:0] prdata_comb;

  always_comb begin
    prdata_comb = 32'hA5A5_5A5A;
    if (PSEL[0]) prdata_comb = slv_mem[0][PADDR[5:2]];
    if (PSEL[1]) prdata_comb = slv_mem[1][PADDR[5:2]];
    if (PSEL[2]) prdata_comb = slv_mem[2][PADDR[5:2]];
  end

  always @(posedge HCLK) begin
    if (PENABLE && PWRITE) begin
      if (PSEL[0]) slv_mem[0][PADDR[5:2]] <= PWDATA;
      if (PSEL[1]) slv_mem[1][PADDR[5:2]] <= PWDATA;
      if (PSEL[2]) slv_mem[2][PADDR[5:2]] <= PWDATA;
    end
  end

`ifdef AHB_APB_RDATA_DELAY_EN
  logic [31:0] prdata_r = 32'hA5A5_5A5A;
  always @(posedge HCLK) begin
    prdata_r <= (PSEL != 3'b000 && PENABLE && !PWRITE) ? prdata_comb : 32'h5A5A_A5A5;
  end
  assign PRDATA = prdata_r;
`else
  assign PRDATA = prdata_comb;
`endif

  // ---------------- behavioural model ----------------
  typedef struct {
    logic        hready;
    logic [1:0]  hresp;
    logic [2:0]  psel;
    logic        penable;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic        pwrite;
    logic [31:0] hrdata;
  } exp_t;

  exp_t        tl[$];          // expected outputs, one entry per busy cycle
  logic [31:0] cur_paddr = '0, cur_pwdata = '0, cur_hrdata = '0;
  logic        cur_pwrite = 1'b0;
  logic [31:0] mdl_mem [3][16];
  bit          in_reset = 1'b1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t idle_exp();
    exp_t e;
    e.hready = 1'b1; e.hresp = 2'b00; e.psel = 3'b000; e.penable = 1'b0;
    e.paddr = cur_paddr; e.pwdata = cur_pwdata; e.pwrite = cur_pwrite;
    e.hrdata = cur_hrdata;
    return e;
  endfunction

  // Called in the first cycle after the accepting edge: lays out what every
  // busy cycle of this transfer must look like, then moves the steady-state
  // values to their post-transfer contents.
  task automatic push_model(input logic [31:0] addr, input bit wr, input logic [31:0] wdata);
    exp_t e;
    int   d;
    d = int'(addr[31:16]) - int'(SLV_BASE);
    e.hready = 1'b0; e.hresp = 2'b00; e.psel = 3'b000; e.penable = 1'b0;
    e.paddr = addr; e.pwrite = wr; e.pwdata = cur_pwdata; e.hrdata = cur_hrdata;
    if (d < 0 || d > 2) begin
      e.hresp = 2'b01;
      tl.push_back(e);
      e.hready = 1'b1;
      tl.push_back(e);
    end else begin
      tl.push_back(e);
      if (wr) e.pwdata = wdata;
      e.psel = 3'(1 << d);
      tl.push_back(e);
      e.penable = 1'b1;
      tl.push_back(e);
      if (!wr && RD_STALL == 4) begin
        e.psel = 3'b000; e.penable = 1'b0;
        tl.push_back(e);
      end
      if (wr) begin
        cur_pwdata = wdata;
        mdl_mem[d][addr[5:2]] = wdata;
      end else begin
        cur_hrdata = mdl_mem[d][addr[5:2]];
      end
    end
    cur_paddr  = addr;
    cur_pwrite = wr;
  endtask

  // Cycle-by-cycle compare against the model
  always @(negedge HCLK) begin
    exp_t e;
    if (!in_reset) begin
      if (tl.size() > 0) e = tl.pop_front();
      else e = idle_exp();
      chk("HREADY_OUT", 32'(HREADY_OUT), 32'(e.hready));
      chk("HRESP", 32'(HRESP), 32'(e.hresp));
      chk("PSEL", 32'(PSEL), 32'(e.psel));
      chk("PENABLE", 32'(PENABLE), 32'(e.penable));
      chk("PADDR", PADDR, e.paddr);
      chk("PWDATA", PWDATA, e.pwdata);
      chk("PWRITE", 32'(PWRITE), 32'(e.pwrite));
      chk("HRDATA", HRDATA, e.hrdata);
    end
  end

  // ---------------- AHB master ----------------
  int          last_stalls, last_resp;
  logic [2:0]  last_psel_or, acc_psel;
  logic [31:0] acc_paddr, acc_pwdata;
  logic        acc_pwrite;

  task automatic wait_idle();
    int k = 0;
    while (tl.size() != 0 && k < 20) begin
      @(posedge HCLK); #1;
      k++;
    end
    if (tl.size() != 0) begin
      errors++;
      $display("FAIL wait_idle: model still busy after %0d cycles", k);
      tl.delete();
    end
  endtask

  // Entered at posedge+1 with the bridge idle; returns in the completion
  // cycle (first cycle with HREADY_OUT high after the address phase).
  task automatic do_xfer(input logic [31:0] addr, input bit wr, input logic [31:0] wdata,
                         input logic [1:0] htr, input logic [2:0] hb);
    int k;
    bit done;
    HADDR = addr; HWRITE = wr; HTRANS = htr; HBURST = hb; HREADY_IN = 1'b1;
    HSIZE = 3'($urandom_range(0, 7)); HWDATA = $urandom;
    @(posedge HCLK); #1;
    HTRANS = 2'b00; HADDR = $urandom; HWRITE = 1'($urandom);
    HWDATA = wr ? wdata : $urandom;
    push_model(addr, wr, wdata);
    last_stalls = 0; last_resp = 0; last_psel_or = 3'b000;
    acc_psel = 3'b000; acc_paddr = '0; acc_pwdata = '0; acc_pwrite = 1'b0;
    k = 0; done = 1'b0;
    while (!done && k < 12) begin
      if (HREADY_OUT) done = 1'b1;
      else last_stalls++;
      if (HRESP == 2'b01) last_resp++;
      last_psel_or |= PSEL;
      if (PENABLE) begin
        acc_psel = PSEL; acc_paddr = PADDR; acc_pwdata = PWDATA; acc_pwrite = PWRITE;
      end
      if (!done) begin
        @(posedge HCLK); #1;
        HWDATA = $urandom;
        k++;
      end
    end
    if (!done) begin
      errors++;
      $display("FAIL xfer_timeout: addr %h never completed", addr);
    end
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    int          d;
    a = $urandom;
    a[1:0] = 2'b00;
    if ($urandom_range(0, 4) != 0) begin
      a[31:16] = SLV_BASE + 16'($urandom_range(0, 2));
    end else begin
      d = int'(a[31:16]) - int'(SLV_BASE);
      case ($urandom_range(0, 2))
        0: a[31:16] = SLV_BASE - 16'd1;
        1: a[31:16] = SLV_BASE + 16'd3;
        default: if (d >= 0 && d <= 2) a[31:16] = 16'hFFFF;
      endcase
    end
    return a;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, saved_mem, saved_paddr, saved_pwdata, saved_hrdata;
    bit          saved_pwrite;
    int          d;

    for (int s = 0; s < 3; s++)
      for (int w = 0; w < 16; w++) mdl_mem[s][w] = '0;

    // reset
    #1 PRESETn = 1'b0;
    @(posedge HCLK); @(posedge HCLK); #1;
    chk("rst_HRDATA", HRDATA, 32'h0);
    chk("rst_HREADY_OUT", 32'(HREADY_OUT), 32'h1);
    chk("rst_HRESP", 32'(HRESP), 32'h0);
    chk("rst_PADDR", PADDR, 32'h0);
    chk("rst_PWDATA", PWDATA, 32'h0);
    chk("rst_PSEL", 32'(PSEL), 32'h0);
    chk("rst_PENABLE", 32'(PENABLE), 32'h0);
    chk("rst_PWRITE", 32'(PWRITE), 32'h0);
    #1 PRESETn = 1'b1;
    in_reset = 1'b0;
    @(posedge HCLK); #1;

    // directed transfers with literal expectations
    do_xfer(32'h8000_0004, 1'b1, 32'hDEADBEEF, 2'b10, 3'b000);
    chk("w0_stalls", 32'(last_stalls), 32'd3);
    chk("w0_psel", 32'(acc_psel), 32'h1);
    chk("w0_paddr", acc_paddr, 32'h8000_0004);
    chk("w0_pwdata", acc_pwdata, 32'hDEADBEEF);
    chk("w0_pwrite", 32'(acc_pwrite), 32'h1);
    chk("w0_resp", 32'(last_resp), 32'd0);
    wait_idle();
    do_xfer(32'h8000_0004, 1'b0, 32'h0, 2'b10, 3'b000);
    chk("r0_stalls", 32'(last_stalls), 32'(RD_STALL));
    chk("r0_hrdata", HRDATA, 32'hDEADBEEF);
    wait_idle();

    do_xfer(32'h8001_0008, 1'b1, 32'h12345678, 2'b10, 3'b000);
    chk("w1_psel", 32'(acc_psel), 32'h2);
    wait_idle();
    do_xfer(32'h8001_0008, 1'b0, 32'h0, 2'b10, 3'b000);
    chk("r1_psel", 32'(acc_psel), 32'h2);
    chk("r1_hrdata", HRDATA, 32'h12345678);
    wait_idle();

    do_xfer(32'h8002_000C, 1'b1, 32'hABCDEF00, 2'b10, 3'b000);
    chk("w2_psel", 32'(acc_psel), 32'h4);
    wait_idle();
    do_xfer(32'h8002_000C, 1'b0, 32'h0, 2'b10, 3'b000);
    chk("r2_hrdata", HRDATA, 32'hABCDEF00);
    wait_idle();

    for (int i = 0; i < 4; i++) begin
      do_xfer(32'h8000_0010 + 32'(4 * i), 1'b1, 32'h11111111 + 32'(i),
              (i == 0) ? 2'b10 : 2'b11, 3'b011);
      chk("incr4_w_paddr", acc_paddr, 32'h8000_0010 + 32'(4 * i));
      wait_idle();
    end
    for (int i = 0; i < 4; i++) begin
      do_xfer(32'h8000_0010 + 32'(4 * i), 1'b0, 32'h0, (i == 0) ? 2'b10 : 2'b11, 3'b011);
      chk("incr4_r_hrdata", HRDATA, 32'h11111111 + 32'(i));
      wait_idle();
    end

    do_xfer(32'hFFFF_FFFF, 1'b1, 32'h0BAD_0BAD, 2'b10, 3'b000);
    chk("err_stalls", 32'(last_stalls), 32'd1);
    chk("err_resp_cycles", 32'(last_resp), 32'd2);
    chk("err_psel", 32'(last_psel_or), 32'h0);
    wait_idle();
    chk("err_after_hresp", 32'(HRESP), 32'h0);
    chk("err_after_hready", 32'(HREADY_OUT), 32'h1);
    chk("err_after_hrdata", HRDATA, 32'h11111114);

    // randomized traffic with ignored cycles in between
    for (int t = 0; t < 300; t++) begin
      int gap;
      wait_idle();
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        HADDR = {SLV_BASE, 16'($urandom)};
        HWRITE = 1'($urandom);
        HWDATA = $urandom;
        case ($urandom_range(0, 2))
          0: begin HTRANS = 2'b00; HREADY_IN = 1'b1; end
          1: begin HTRANS = 2'b01; HREADY_IN = 1'b1; end
          default: begin HTRANS = 2'($urandom_range(2, 3)); HREADY_IN = 1'b0; end
        endcase
        @(posedge HCLK); #1;
      end
      a = rand_addr();
      do_xfer(a, 1'($urandom), $urandom, 2'($urandom_range(2, 3)), 3'($urandom_range(0, 7)));
    end
    wait_idle();

    // reset asserted in the middle of ACCESS of a write
    a = 32'h8001_0020;
    d = 1;
    saved_mem = mdl_mem[d][a[5:2]];
    saved_paddr = cur_paddr; saved_pwdata = cur_pwdata;
    saved_hrdata = cur_hrdata; saved_pwrite = cur_pwrite;
    HADDR = a; HWRITE = 1'b1; HTRANS = 2'b10; HREADY_IN = 1'b1;
    @(posedge HCLK); #1;
    HTRANS = 2'b00;
    HWDATA = 32'hCAFE_F00D;
    push_model(a, 1'b1, 32'hCAFE_F00D);
    @(posedge HCLK); #1;
    HWDATA = $urandom;
    @(posedge HCLK); #1;
    chk("rst_mid_penable", 32'(PENABLE), 32'h1);
    in_reset = 1'b1;
    tl.delete();
    PRESETn = 1'b0;
    #1;
    chk("rst_mid_HRDATA", HRDATA, 32'h0);
    chk("rst_mid_HREADY_OUT", 32'(HREADY_OUT), 32'h1);
    chk("rst_mid_HRESP", 32'(HRESP), 32'h0);
    chk("rst_mid_PADDR", PADDR, 32'h0);
    chk("rst_mid_PWDATA", PWDATA, 32'h0);
    chk("rst_mid_PSEL", 32'(PSEL), 32'h0);
    chk("rst_mid_PENABLE", 32'(PENABLE), 32'h0);
    chk("rst_mid_PWRITE", 32'(PWRITE), 32'h0);
    mdl_mem[d][a[5:2]] = saved_mem;
    cur_paddr = '0; cur_pwdata = '0; cur_hrdata = '0; cur_pwrite = 1'b0;
    if (saved_paddr === 32'hx || saved_pwdata === 32'hx || saved_hrdata === 32'hx ||
        saved_pwrite === 1'bx) $display("note: model held unknown values before reset");
    @(posedge HCLK); @(posedge HCLK); #2;
    PRESETn = 1'b1;
    in_reset = 1'b0;
    @(posedge HCLK); #1;
    do_xfer(a, 1'b0, 32'h0, 2'b10, 3'b000);
    chk("rst_abort_readback", HRDATA, saved_mem);
    wait_idle();
    @(posedge HCLK); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
